dkong_i2s_tx: RTL and testbench
===============================

# dkong_i2s_tx

Serial audio output stage for the Donkey Kong sound path. It takes the 16-bit offset-binary mix produced by the sound board at its 48 kHz sample strobe and converts it to two's complement. It applies a click-free soft mute/start gain ramp and transmits the result as a standard I2S stream (mono duplicated to L/R) to an external DAC, with all serial clocks derived from the 24.576 MHz system clock.

## Interface
- RAMP_STEP, 1, gain change per frame (gain range 0..256, clamped)
- W_CLK_24576M  in  1  system clock, 24.576 MHz
- W_RESETn  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- I_SAMPLE  in  16  sound mix, unsigned offset binary (0x8000 = silence)
- I_SAMPLE_EN  in  1  one-cycle strobe, nominally 48 kHz; I_SAMPLE valid when high
- I_MUTE  in  1  level; 1 = ramp gain to 0, 0 = ramp gain to 256
- O_MCLK  out  1  12.288 MHz (256 fs)
- O_BCLK  out  1  3.072 MHz (64 fs)
- O_LRCK  out  1  48 kHz word select, 0 = left
- O_SDATA  out  1  I2S serial data, MSB first
- O_FRAME_STB  out  1  one-cycle pulse on frame load
- O_OVERRUN  out  1  sticky: a pending sample was overwritten before being loaded

## Operation
- Frame counter fc, 9 bits, free-running, +1 every clock, wraps 511→0. O_MCLK = fc[0], O_BCLK = fc[2], O_LRCK = fc[8]; all registered, no combinational outputs.
- Slot index = fc[7:3], 32 slots per half-frame. I2S format: slot 0 = 0 (one-BCLK delay after LRCK edge), slots 1..16 carry word bits 15..0, slots 17..31 = 0. Both halves transmit the same word.
- O_SDATA updates on BCLK falling edge: at fc[2:0]==7, O_SDATA is loaded with the bit for slot of fc+1 (including across the 255→256 and 511→0 boundaries).
- Capture: on I_SAMPLE_EN, pend <= I_SAMPLE ^ 16'h8000; pend_valid <= 1. If pend_valid was already 1 and no load occurs that cycle, O_OVERRUN <= 1. A later sample overwrites an earlier one.
- Load at fc==511 (new frame starts at fc==0): O_FRAME_STB = 1 for that cycle. If pend_valid, word <= (pend * g) >>> 8, signed 16×9-bit, arithmetic shift, floor toward −inf, result fits 16 bits; pend_valid <= 0. Otherwise the word is recomputed from the last loaded pend value with the current g, so held samples still ramp.
- Gain g, 9 bits, 0..256. Updated at the load cycle after word computation, so the word uses the old g. I_MUTE=1: g <= max(g−RAMP_STEP, 0); else g <= min(g+RAMP_STEP, 256). g=256 is exact pass-through.
- Simultaneous I_SAMPLE_EN and load: the load uses pend as it was before the edge. The new sample becomes pending for the next frame. If pend was empty, the hold rule applies. No overrun is flagged.

## Timing
- Reset values: fc=0, O_MCLK=O_BCLK=O_LRCK=O_SDATA=0, O_FRAME_STB=0, O_OVERRUN=0, g=0 (soft start), pend=0, pend_valid=0, word=0.
- Latency: a sample captured at least 1 cycle before fc==511 is loaded at fc==511. Its MSB is driven from fc==8 (left slot 1) and its LSB ends at fc==135. Worst case from capture to MSB is 521 clocks.
- Full ramp 0→256 takes 256/RAMP_STEP frames (5.33 ms at step 1).
- Reset mid-frame: all state returns to reset values immediately (async). Counting restarts at fc=0 on the first clock after release, and the stream restarts with a zero word.

## Test plan
- Reset: hold W_RESETn low mid-frame -> all outputs 0, fc=0. After release, O_LRCK rises at fc==256, O_BCLK period is 8 clocks, O_MCLK period is 2 clocks.
- Soft start/pass-through: I_MUTE=0, I_SAMPLE=0xC000 strobed every 512 clocks. First frame word = 0x0000. After 256 frames, word = 0x4000 on slots 1..16 of both halves, slots 0 and 17..31 = 0.
- Gain arithmetic at g=128: I_SAMPLE=0xFFFF -> word 0x3FFF. I_SAMPLE=0x0000 -> word 0xC000. I_SAMPLE=0x8000 -> word 0x0000.
- Mute: at g=256, assert I_MUTE with constant 0xC000 and no further strobes -> held word decreases by 0x40 per frame and reaches 0 after 256 frames. g stays at 0.
- Overrun/hold: two strobes (0x9000 then 0xA000) within one frame -> 0x2000-derived word transmitted, O_OVERRUN=1 and sticky. Next frame with no strobe repeats the same word.
- Collision: strobe exactly at fc==511 with pend empty -> previous word repeated, new sample loaded at the following fc==511, O_OVERRUN stays 0, O_FRAME_STB pulses once per 512 clocks.

Source files
------------

// File: rtl/dkong_i2s_tx_if.sv
// ---------------------------------------------------------------------------
// dkong_i2s_tx_if
//
// Bundles the sample input side and the I2S/status output side of the
// Donkey Kong audio output stage.
//
//   sample     16  sound mix, unsigned offset binary (0x8000 = silence)
//   sample_en   1  one-cycle strobe, sample valid when high
//   mute        1  level; 1 = ramp gain down to 0, 0 = ramp up to 256
//   mclk        1  master clock, 256 fs
//   bclk        1  bit clock, 64 fs
//   lrck        1  word select, 0 = left
//   sdata       1  I2S serial data, MSB first
//   frame_stb   1  one-cycle pulse on the frame load cycle
//   overrun     1  sticky: a pending sample was overwritten before loading
//
// master = sound board / stimulus side, slave = the transmitter.
// ---------------------------------------------------------------------------
interface dkong_i2s_tx_if;
    logic [15:0] sample;
    logic        sample_en;
    logic        mute;
    logic        mclk;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic        frame_stb;
    logic        overrun;

    modport master (
        output sample, sample_en, mute,
        input  mclk, bclk, lrck, sdata, frame_stb, overrun
    );

    modport slave (
        input  sample, sample_en, mute,
        output mclk, bclk, lrck, sdata, frame_stb, overrun
    );
endinterface

// File: rtl/dkong_i2s_tx.sv
// ---------------------------------------------------------------------------
// dkong_i2s_tx
//
// Serial audio output stage. Captures the 16-bit offset-binary mix on its
// sample strobe, converts it to two's complement, applies a soft mute/start
// gain ramp (0..256, exact pass-through at 256) once per frame and sends the
// result as a mono-duplicated I2S stream. All serial clocks come from one
// free-running 9-bit frame counter (512 system clocks per stereo frame).
//
// Ports:
//   W_CLK_24576M  in   system clock, 24.576 MHz
//   W_RESETn      in   asynchronous active-low reset
//   bus           slave modport of dkong_i2s_tx_if (sample in, I2S out)
//
// Parameter:
//   RAMP_STEP     gain change applied at each frame load (1..256)
// ---------------------------------------------------------------------------
module dkong_i2s_tx #(
    parameter int RAMP_STEP = 1
) (
    input  logic          W_CLK_24576M,
    input  logic          W_RESETn,
    dkong_i2s_tx_if.slave bus
);

    localparam logic [8:0] G_MAX   = 9'd256;
    localparam logic [8:0] STEP    = 9'(RAMP_STEP);
    localparam logic [8:0] FC_LAST = 9'd511;

    // Frame counter: bit 0 = MCLK, bit 2 = BCLK, bit 8 = LRCK, [7:3] = slot.
    logic [8:0]  fc;
    logic [8:0]  fc_nxt;
    logic        load;

    // Sample path.
    logic [15:0] pend;        // two's complement, waiting for the next load
    logic        pend_valid;
    logic [15:0] word;        // scaled word being transmitted this frame
    logic [8:0]  gain;

    // Registered outputs.
    logic        mclk_q;
    logic        bclk_q;
    logic        lrck_q;
    logic        sdata_q;
    logic        frame_stb_q;
    logic        overrun_q;

    // Next-value logic.
    logic signed [25:0] product;
    logic [15:0]        word_nxt;
    logic [8:0]         gain_nxt;
    logic [4:0]         slot_nxt;
    logic               sdata_nxt;
    logic               unused_product_bits;

    assign load = (fc == FC_LAST);

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the block can leave a value held and infer a latch.
    always_comb begin
        fc_nxt    = fc + 9'd1;
        product   = '0;
        word_nxt  = '0;
        gain_nxt  = gain;
        slot_nxt  = fc_nxt[7:3];
        sdata_nxt = 1'b0;

        // Signed 16 x 9 multiply. Gain is always non-negative, so it is
        // zero-extended before being treated as signed. Taking bits [23:8]
        // is an arithmetic shift by 8, i.e. floor toward -inf; with
        // gain <= 256 the result always fits in 16 bits.
        product  = $signed(pend) * $signed({1'b0, gain});
        word_nxt = product[23:8];

        // Ramp with clamping. Compares happen before the add/subtract so
        // nothing can wrap in 9 bits.
        if (bus.mute) begin
            gain_nxt = (gain <= STEP) ? 9'd0 : gain - STEP;
        end else begin
            gain_nxt = (gain >= G_MAX - STEP) ? G_MAX : gain + STEP;
        end

        // Bit for the slot that begins on the next BCLK falling edge.
        // Slot 0 is the one-BCLK I2S delay, slots 1..16 carry bits 15..0,
        // slots 17..31 are padding. Across 255->256 and 511->0 the next slot
        // is 0, so the word register changing at 511 never reaches the pin.
        if (slot_nxt != 5'd0 && slot_nxt <= 5'd16) begin
            sdata_nxt = word[4'(5'd16 - slot_nxt)];
        end
    end

    assign unused_product_bits = ^{product[25:24], product[7:0]};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its inputs regardless of the
    // order in which statements appear.
    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            fc          <= '0;
            mclk_q      <= 1'b0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
            frame_stb_q <= 1'b0;
            overrun_q   <= 1'b0;
            pend        <= '0;
            pend_valid  <= 1'b0;
            word        <= '0;
            gain        <= '0;      // soft start from silence
        end else begin
            fc <= fc_nxt;

            // Clock outputs are registered copies of the next counter value,
            // so they always equal the current counter bits with no
            // combinational path to the pins.
            mclk_q      <= fc_nxt[0];
            bclk_q      <= fc_nxt[2];
            lrck_q      <= fc_nxt[8];
            frame_stb_q <= (fc_nxt == FC_LAST);

            if (fc[2:0] == 3'd7) begin
                sdata_q <= sdata_nxt;
            end

            // Frame load: the word is always rebuilt from pend with the gain
            // as it was before this edge. When no new sample arrived, pend
            // still holds the last loaded value, so a held sample keeps
            // following the ramp.
            if (load) begin
                word <= word_nxt;
                gain <= gain_nxt;
            end

            // A strobe coinciding with the load is captured for the next
            // frame; the load above already used the old pend.
            if (bus.sample_en) begin
                pend       <= bus.sample ^ 16'h8000;
                pend_valid <= 1'b1;
                if (pend_valid && !load) begin
                    overrun_q <= 1'b1;
                end
            end else if (load) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign bus.mclk      = mclk_q;
    assign bus.bclk      = bclk_q;
    assign bus.lrck      = lrck_q;
    assign bus.sdata     = sdata_q;
    assign bus.frame_stb = frame_stb_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_dkong_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_dkong_i2s_tx
//
// Drives dkong_i2s_tx frame by frame. A small reference model tracks the
// pending sample, gain and transmitted word with integer arithmetic; an I2S
// receiver in the bench reassembles each 32-slot half-frame from O_SDATA and
// compares it with the model. Directed frames cover soft start, clamping,
// mute, gain-128 arithmetic, overrun/hold, reset and the load collision;
// random frames follow.
// ---------------------------------------------------------------------------
module tb_dkong_i2s_tx;

    localparam int STEP = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dkong_i2s_tx_if bus_if ();

    dkong_i2s_tx #(.RAMP_STEP(STEP)) dut (
        .W_CLK_24576M (clk),
        .W_RESETn     (rst_n),
        .bus          (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    int          f;          // frame counter position of the current cycle
    int          m_pend;     // pending sample as a signed integer
    int          m_gain;
    logic [15:0] m_word;
    bit          m_valid;
    bit          m_ovr;

    // Receiver / per-frame bookkeeping.
    logic [31:0] rx;
    logic [15:0] last_left;
    logic [15:0] last_right;
    int          clk_err;
    int          stb_err;

    // Strobes scheduled for the next frame.
    int          spos [4];
    logic [15:0] sval [4];
    int          s_cnt;

    // floor(s * g / 256) in plain integer arithmetic.
    function automatic logic [15:0] scale(input int s, input int g);
        int p;
        int q;
        p = s * g;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return 16'(q);
    endfunction

    task automatic model_reset();
        f       = 0;
        m_pend  = 0;
        m_gain  = 0;
        m_word  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        rx      = '0;
        clk_err = 0;
        stb_err = 0;
    endtask

    // One clock: observe the current cycle, drive inputs for the coming
    // edge, then advance the model across that edge.
    task automatic step(input bit en, input logic [15:0] s, input bit mute_v);
        bit was_valid;
        @(negedge clk);
        if (bus_if.mclk !== f[0] || bus_if.bclk !== f[2] || bus_if.lrck !== f[8])
            clk_err++;
        if (bus_if.frame_stb !== (f == 511))
            stb_err++;
        if (f % 8 == 4)
            rx = {rx[30:0], bus_if.sdata};
        if (f == 255) begin
            check("left_half", rx, {1'b0, m_word, 15'b0});
            last_left = rx[30:15];
        end
        if (f == 511) begin
            check("right_half", rx, {1'b0, m_word, 15'b0});
            last_right = rx[30:15];
            check("clock_outs", clk_err, 0);
            check("frame_stb", stb_err, 0);
            check("overrun", bus_if.overrun, m_ovr);
            clk_err = 0;
            stb_err = 0;
        end

        bus_if.sample_en = en;
        bus_if.sample    = s;
        bus_if.mute      = mute_v;

        was_valid = m_valid;
        if (f == 511) begin
            m_word = scale(m_pend, m_gain);
            if (mute_v) m_gain = (m_gain - STEP < 0) ? 0 : m_gain - STEP;
            else        m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
            m_valid = 1'b0;
        end
        if (en) begin
            if (was_valid && f != 511) m_ovr = 1'b1;
            m_pend  = int'($signed(s ^ 16'h8000));
            m_valid = 1'b1;
        end
        f = (f + 1) % 512;
    endtask

    task automatic add_strobe(input int p, input logic [15:0] v);
        spos[s_cnt] = p;
        sval[s_cnt] = v;
        s_cnt++;
    endtask

    // Runs the remainder of the current frame with the scheduled strobes.
    task automatic run_frame(input bit mute_v);
        bit          en;
        logic [15:0] v;
        while (1) begin
            en = 1'b0;
            v  = '0;
            for (int k = 0; k < s_cnt; k++) begin
                if (spos[k] == f) begin
                    en = 1'b1;
                    v  = sval[k];
                end
            end
            step(en, v, mute_v);
            if (f == 0) break;
        end
        s_cnt = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [5:0] outs();
        return {bus_if.mclk, bus_if.bclk, bus_if.lrck,
                bus_if.sdata, bus_if.frame_stb, bus_if.overrun};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.sample    = '0;
        bus_if.sample_en = 1'b0;
        bus_if.mute      = 1'b0;
        s_cnt            = 0;
        last_left        = '0;
        last_right       = '0;
        model_reset();

        #23;
        check("reset_outs", outs(), 6'd0);
        release_reset();

        // Soft start: gain 0,32,..,256 over nine loads.
        for (int k = 0; k < 10; k++) begin
            add_strobe($urandom_range(0, 510), 16'hC000);
            run_frame(1'b0);
            if (k == 1) check("soft_start_first", last_left, 16'h0000);
        end
        check("pass_through_l", last_left, 16'h4000);
        check("pass_through_r", last_right, 16'h4000);
        add_strobe($urandom_range(0, 510), 16'hC000);
        run_frame(1'b0);
        check("gain_clamp_hi", last_left, 16'h4000);

        // Mute with the held sample, no further strobes.
        for (int j = 0; j < 11; j++) begin
            run_frame(1'b1);
            if (j == 2) check("mute_step", last_left, 16'h3800);
        end
        check("mute_floor", last_left, 16'h0000);

        // Gain 128 arithmetic: ramp back up to 128.
        for (int k = 0; k < 4; k++) begin
            add_strobe($urandom_range(0, 510), 16'($urandom));
            run_frame(1'b0);
        end
        add_strobe($urandom_range(0, 510), 16'hFFFF);
        run_frame(1'b0);
        run_frame(1'b1);
        check("g128_ffff", last_left, 16'h3FFF);
        add_strobe($urandom_range(0, 510), 16'h0000);
        run_frame(1'b1);
        run_frame(1'b0);
        check("g128_0000", last_left, 16'hC000);
        add_strobe($urandom_range(0, 510), 16'h8000);
        run_frame(1'b0);
        run_frame(1'b0);
        check("g128_8000", last_left, 16'h0000);

        // Overrun and hold at full gain.
        for (int k = 0; k < 3; k++) run_frame(1'b0);
        add_strobe($urandom_range(0, 250), 16'h9000);
        add_strobe($urandom_range(251, 510), 16'hA000);
        run_frame(1'b0);
        run_frame(1'b0);
        check("overrun_word", last_left, 16'h2000);
        check("overrun_sticky", bus_if.overrun, 1'b1);
        run_frame(1'b0);
        check("hold_repeat", last_right, 16'h2000);

        // Reset in the middle of a frame.
        for (int i = 0; i < 300; i++) step(1'b0, 16'h0000, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("reset_mid", outs(), 6'd0);
        repeat (3) @(negedge clk);
        check("reset_hold", outs(), 6'd0);
        release_reset();

        // Collision: strobe exactly on the load cycle with pend empty.
        add_strobe($urandom_range(0, 510), 16'hE000);
        run_frame(1'b0);
        run_frame(1'b0);
        add_strobe(511, 16'h1234);
        run_frame(1'b0);
        check("collision_prev", last_left, 16'h0C00);
        run_frame(1'b0);
        check("collision_hold", last_left, 16'h1800);
        check("collision_no_ovr", bus_if.overrun, 1'b0);
        run_frame(1'b0);
        check("collision_new", last_left, 16'hD6D3);

        // Random traffic.
        for (int k = 0; k < 24; k++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++)
                add_strobe($urandom_range(0, 511), 16'($urandom));
            run_frame(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
